// File: rtl/alu_8bit_if.sv
// Operand/opcode request and registered result bundle for the alu_8bit execute unit.
// The master drives operands; the slave (the ALU) returns result and flags.
interface alu_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [2:0]       c;
    logic [WIDTH-1:0] data_out;
    logic             carry;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, src_a, src_b, c,
        input  data_out, carry, zero, out_valid
    );

    modport slave (
        input  in_valid, src_a, src_b, c,
        output data_out, carry, zero, out_valid
    );
endinterface

// File: rtl/alu_8bit.sv
// Eight-operation unsigned integer ALU with a single registered output stage.
// A result is loaded on every valid edge; flags and data hold otherwise.
module alu_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    alu_8bit_if.slave    bus_io
);
    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpOr   = 3'b011,
        OpXor  = 3'b100,
        OpShl  = 3'b101,
        OpShr  = 3'b110,
        OpSltu = 3'b111
    } op_e;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             zero_d;

    logic [WIDTH-1:0] data_q;
    logic             carry_q;
    logic             zero_q;
    logic             valid_q;

    // diff[WIDTH] is the borrow, shared by SUB and SLTU.
    always_comb begin
        sum      = {1'b0, bus_io.src_a} + {1'b0, bus_io.src_b};
        diff     = {1'b0, bus_io.src_a} - {1'b0, bus_io.src_b};
        result_d = '0;
        carry_d  = 1'b0;
        unique case (op_e'(bus_io.c))
            OpAdd: begin
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
            end
            OpSub: begin
                result_d = diff[WIDTH-1:0];
                carry_d  = diff[WIDTH];
            end
            OpAnd:  result_d = bus_io.src_a & bus_io.src_b;
            OpOr:   result_d = bus_io.src_a | bus_io.src_b;
            OpXor:  result_d = bus_io.src_a ^ bus_io.src_b;
            OpShl:  result_d = bus_io.src_a << bus_io.src_b[2:0];
            OpShr:  result_d = bus_io.src_a >> bus_io.src_b[2:0];
            OpSltu: result_d = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus_io.in_valid;
            if (bus_io.in_valid) begin
                data_q  <= result_d;
                carry_q <= carry_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign bus_io.data_out  = data_q;
    assign bus_io.carry     = carry_q;
    assign bus_io.zero      = zero_q;
    assign bus_io.out_valid = valid_q;
endmodule

// File: tb/tb_alu_8bit.sv
// Randomized self-checking bench for alu_8bit against an arithmetic reference model.
module tb_alu_8bit;
    logic clk;
    logic rst_n;

    alu_8bit_if #(.WIDTH(8)) bus ();

    alu_8bit #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_bad;

    // Expected registered state, maintained by the model.
    int exp_data;
    int exp_carry;
    int exp_zero;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {carry, result}, computed with plain integer arithmetic.
    function automatic int ref_alu(input int a, input int b, input int op);
        int res;
        int cy;
        cy = 0;
        case (op)
            0: begin res = (a + b) % 256; cy = (a + b) / 256; end
            1: begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (a * (1 << (b % 8))) % 256;
            6: res = a / (1 << (b % 8));
            default: res = (a < b) ? 1 : 0;
        endcase
        return cy * 256 + res;
    endfunction

    task automatic check_outputs(input string tag, input int exp_valid);
        check({tag, ".data"},  32'(bus.data_out),  32'(exp_data));
        check({tag, ".carry"}, 32'(bus.carry),     32'(exp_carry));
        check({tag, ".zero"},  32'(bus.zero),      32'(exp_zero));
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(exp_valid));
    endtask

    // Called #1 after an edge; drives inputs, waits one edge, checks.
    task automatic apply(input string tag, input int v, input int a, input int b, input int op);
        int r;
        bus.in_valid = v[0];
        bus.src_a    = a[7:0];
        bus.src_b    = b[7:0];
        bus.c        = op[2:0];
        @(posedge clk);
        #1;
        if (v != 0) begin
            r         = ref_alu(a, b, op);
            exp_data  = r % 256;
            exp_carry = r / 256;
            exp_zero  = (exp_data == 0) ? 1 : 0;
        end
        check_outputs(tag, v);
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        n_vec = 0;
        n_bad = 0;
        exp_data = 0;
        exp_carry = 0;
        exp_zero = 0;
        sweep_exp = '{8'h6F, 8'h3B, 8'h10, 8'h5F, 8'h4F, 8'h54, 8'h15, 8'h00};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.src_a = 8'h00;
        bus.src_b = 8'h00;
        bus.c = 3'd0;
        #3;
        check_outputs("reset", 0);
        #9;
        rst_n = 1'b1;

        // Opcode sweep against fixed expected results.
        for (int op = 0; op < 8; op++) begin
            bus.in_valid = 1'b1;
            bus.src_a = 8'h55;
            bus.src_b = 8'h1A;
            bus.c = 3'(op);
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d.data", op), 32'(bus.data_out), 32'(sweep_exp[op]));
            check($sformatf("sweep%0d.carry", op), 32'(bus.carry), 32'd0);
            check($sformatf("sweep%0d.zero", op), 32'(bus.zero), (op == 7) ? 32'd1 : 32'd0);
            check($sformatf("sweep%0d.valid", op), 32'(bus.out_valid), 32'd1);
        end
        exp_data = 0; exp_carry = 0; exp_zero = 1;

        apply("add_ovf", 1, 8'hFF, 8'h01, 0);
        check("add_ovf.lit", {bus.carry, bus.zero, bus.data_out}, {1'b1, 1'b1, 8'h00});
        apply("sub_borrow", 1, 8'h1A, 8'h55, 1);
        check("sub_borrow.lit", {bus.carry, bus.zero, bus.data_out}, {1'b1, 1'b0, 8'hC5});
        apply("sltu", 1, 8'h1A, 8'h55, 7);
        check("sltu.lit", 32'(bus.data_out), 32'h01);

        // Hold: inputs churn while in_valid is low.
        apply("pre_hold", 1, 8'hF0, 8'h20, 0);
        for (int i = 0; i < 3; i++)
            apply($sformatf("hold%0d", i), 0, $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 7));

        // Async reset between edges; result in flight is discarded.
        apply("pre_rst", 1, 8'h77, 8'h11, 3);
        #3;
        rst_n = 1'b0;
        exp_data = 0; exp_carry = 0; exp_zero = 0;
        #1;
        check_outputs("async_rst", 0);
        bus.in_valid = 1'b1;
        bus.src_a = 8'hFF;
        bus.src_b = 8'hFF;
        bus.c = 3'd0;
        @(posedge clk);
        #1;
        check_outputs("rst_held", 0);
        #2;
        rst_n = 1'b1;
        #2;
        @(posedge clk);
        #1;
        apply("post_rst", 1, 8'h01, 8'h02, 0);
        check("post_rst.lit", 32'(bus.data_out), 32'h03);

        apply("shl_b0", 1, 8'h81, 8'hF8, 5);
        check("shl_b0.lit", 32'(bus.data_out), 32'h81);
        apply("shr7", 1, 8'h80, 8'h07, 6);
        check("shr7.lit", 32'(bus.data_out), 32'h01);
        apply("shl7", 1, 8'h01, 8'h07, 5);
        check("shl7.lit", 32'(bus.data_out), 32'h80);

        for (int i = 0; i < 300; i++)
            apply($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0) ? 1 : 0,
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
